// File: rtl/reorder_queue_ingest.sv
`default_nettype none
// ============================================================================
// Module   : reorder_queue_ingest
// Purpose  : Ingest side of the completion reorder queue. Scatters DW-aligned
//            completion beats into the per-tag data RAM, packing consecutive
//            completions of one tag contiguously. Keeps per-tag DW count,
//            done/error status and internal tag, and exposes a finished-tag
//            bitmap plus a combinational per-tag lookup to the output stage.
// Ports    : CLK/RST         clock, synchronous active-high reset
//            CPL_*           completion beat (tag, data, DW count, last/done/err)
//            MAP_*           tag allocation (tag -> internal tag)
//            WR_EN/ADDR/DATA registered per-lane RAM write port
//            TAG_FINISHED    bitmap of finished tags; TAG_CLEAR releases tags
//            TAG -> TAG_MAPPED, PKT_WORDS, PKT_WORDS_LTE1/2, PKT_DONE, PKT_ERR
//            UNEXP_CPL/OVERFLOW  single-cycle drop indications
// Revision : 1.0 - initial release
// ============================================================================
module reorder_queue_ingest #(
    parameter int C_PCI_DATA_WIDTH         = 128,
    parameter int C_TAG_WIDTH              = 5,
    parameter int C_TAG_DW_COUNT_WIDTH     = 8,
    parameter int C_DATA_ADDR_STRIDE_WIDTH = 5,
    parameter int C_DATA_ADDR_WIDTH        = 10
) (
    input  logic                                                  CLK,
    input  logic                                                  RST,
    input  logic                                                  CPL_VALID,
    input  logic [C_TAG_WIDTH-1:0]                                CPL_TAG,
    input  logic [C_PCI_DATA_WIDTH-1:0]                           CPL_DATA,
    input  logic [$clog2(C_PCI_DATA_WIDTH/32+1)-1:0]              CPL_DW_EN,
    input  logic                                                  CPL_LAST,
    input  logic                                                  CPL_DONE,
    input  logic                                                  CPL_ERR,
    input  logic                                                  MAP_EN,
    input  logic [C_TAG_WIDTH-1:0]                                MAP_TAG,
    input  logic [5:0]                                            MAP_VALUE,
    output logic [C_PCI_DATA_WIDTH/32-1:0]                        WR_EN,
    output logic [(C_PCI_DATA_WIDTH/32)*C_DATA_ADDR_WIDTH-1:0]    WR_ADDR,
    output logic [C_PCI_DATA_WIDTH-1:0]                           WR_DATA,
    output logic [(2**C_TAG_WIDTH)-1:0]                           TAG_FINISHED,
    input  logic [(2**C_TAG_WIDTH)-1:0]                           TAG_CLEAR,
    input  logic [C_TAG_WIDTH-1:0]                                TAG,
    output logic [5:0]                                            TAG_MAPPED,
    output logic [C_TAG_DW_COUNT_WIDTH-1:0]                       PKT_WORDS,
    output logic                                                  PKT_WORDS_LTE1,
    output logic                                                  PKT_WORDS_LTE2,
    output logic                                                  PKT_DONE,
    output logic                                                  PKT_ERR,
    output logic                                                  UNEXP_CPL,
    output logic                                                  OVERFLOW
);

    localparam int c_W       = C_PCI_DATA_WIDTH / 32;
    localparam int c_LW      = (c_W > 1) ? $clog2(c_W) : 1;
    localparam int c_NW      = $clog2(c_W + 1);
    localparam int c_T       = 2 ** C_TAG_WIDTH;
    localparam int c_AW      = C_DATA_ADDR_WIDTH;
    localparam int c_CW      = C_TAG_DW_COUNT_WIDTH;
    localparam int c_CAP_RAM = c_W * (2 ** C_DATA_ADDR_STRIDE_WIDTH);
    localparam int c_CAP_CNT = (2 ** c_CW) - 1;
    localparam int c_CAP     = (c_CAP_RAM < c_CAP_CNT) ? c_CAP_RAM : c_CAP_CNT;

    // Per-tag state
    logic [c_T-1:0]  r_valid;
    logic [c_T-1:0]  r_done;
    logic [c_T-1:0]  r_err;
    logic [c_T-1:0]  r_finished;
    logic [5:0]      r_map   [c_T];
    logic [c_CW-1:0] r_count [c_T];

    // Finish is deferred one cycle so the bitmap never leads the RAM write
    logic                   r_fin_pend;
    logic [C_TAG_WIDTH-1:0] r_fin_tag;

    // Registered write port and pulses
    logic [c_W-1:0]              r_wr_en;
    logic [c_W*c_AW-1:0]         r_wr_addr;
    logic [C_PCI_DATA_WIDTH-1:0] r_wr_data;
    logic                        r_unexp;
    logic                        r_ovf;

    // Beat decode
    logic                   w_mapped;
    logic                   w_map_hit;
    logic [c_CW-1:0]        w_cnt;
    logic [c_CW:0]          w_sum;
    logic [c_LW-1:0]        w_shift;
    logic [c_AW-1:0]        w_row;
    logic [c_AW-1:0]        w_base;
    logic                   w_ovf;
    logic                   w_wr;
    logic                   w_last_fin;

    logic [c_W-1:0]              w_lane_en;
    logic [c_W*c_AW-1:0]         w_lane_addr;
    logic [C_PCI_DATA_WIDTH-1:0] w_lane_data;

    always_comb begin
        // A tag being cleared this cycle is already gone as far as beats go
        w_mapped   = CPL_VALID && r_valid[CPL_TAG] && !TAG_CLEAR[CPL_TAG];
        w_map_hit  = MAP_EN && (MAP_TAG == CPL_TAG);
        w_cnt      = r_count[CPL_TAG];
        w_sum      = {1'b0, w_cnt} + (c_CW+1)'(CPL_DW_EN);
        w_shift    = w_cnt[c_LW-1:0];
        w_row      = c_AW'(w_cnt >> c_LW);
        w_base     = c_AW'(CPL_TAG) << C_DATA_ADDR_STRIDE_WIDTH;
        w_ovf      = w_mapped && (w_sum > (c_CW+1)'(c_CAP));
        w_wr       = w_mapped && !w_ovf;
        w_last_fin = w_mapped && CPL_LAST && (CPL_DONE || CPL_ERR) && !w_map_hit;
    end

    // Lane j receives beat DW (j - shift) mod W; lanes below the shift have
    // wrapped into the next RAM row.
    generate
        for (genvar j = 0; j < c_W; j++) begin : g_lane
            logic [c_LW-1:0] w_rel;
            assign w_rel = c_LW'(j) - w_shift;
            assign w_lane_en[j] = w_wr && (c_NW'(w_rel) < CPL_DW_EN);
            assign w_lane_addr[j*c_AW +: c_AW] =
                w_base + w_row + ((c_LW'(j) < w_shift) ? c_AW'(1) : c_AW'(0));
            assign w_lane_data[j*32 +: 32] = CPL_DATA[w_rel*32 +: 32];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_unexp    <= 1'b0;
            r_ovf      <= 1'b0;
            r_fin_pend <= 1'b0;
            r_fin_tag  <= '0;
        end else begin
            r_wr_en    <= w_lane_en;
            r_wr_addr  <= w_lane_addr;
            r_wr_data  <= w_lane_data;
            r_unexp    <= CPL_VALID && !w_mapped;
            r_ovf      <= w_ovf;
            r_fin_pend <= w_last_fin;
            r_fin_tag  <= CPL_TAG;
        end
    end

    // Priority per tag: allocation, then release, then beat/finish updates
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_finished <= '0;
            for (int i = 0; i < c_T; i++) begin
                r_map[i]   <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_T; i++) begin
                if (MAP_EN && (MAP_TAG == C_TAG_WIDTH'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_map[i]      <= MAP_VALUE;
                    r_count[i]    <= '0;
                    r_done[i]     <= 1'b0;
                    r_err[i]      <= 1'b0;
                    r_finished[i] <= 1'b0;
                end else if (TAG_CLEAR[i]) begin
                    r_valid[i]    <= 1'b0;
                    r_count[i]    <= '0;
                    r_done[i]     <= 1'b0;
                    r_err[i]      <= 1'b0;
                    r_finished[i] <= 1'b0;
                end else begin
                    if (r_fin_pend && (r_fin_tag == C_TAG_WIDTH'(i))) begin
                        r_finished[i] <= 1'b1;
                    end
                    if (w_mapped && (CPL_TAG == C_TAG_WIDTH'(i))) begin
                        if (w_ovf) begin
                            r_err[i] <= 1'b1;
                        end else begin
                            r_count[i] <= w_sum[c_CW-1:0];
                        end
                        if (CPL_LAST) begin
                            if (CPL_ERR) begin
                                r_err[i] <= 1'b1;
                            end
                            if (CPL_DONE || CPL_ERR) begin
                                r_done[i] <= CPL_DONE;
                            end
                        end
                    end
                end
            end
        end
    end

    assign WR_EN          = r_wr_en;
    assign WR_ADDR        = r_wr_addr;
    assign WR_DATA        = r_wr_data;
    assign UNEXP_CPL      = r_unexp;
    assign OVERFLOW       = r_ovf;
    assign TAG_FINISHED   = r_finished;

    assign TAG_MAPPED     = r_map[TAG];
    assign PKT_WORDS      = r_count[TAG];
    assign PKT_WORDS_LTE1 = (r_count[TAG] <= c_CW'(c_W));
    assign PKT_WORDS_LTE2 = (r_count[TAG] <= c_CW'(2 * c_W));
    assign PKT_DONE       = r_done[TAG];
    assign PKT_ERR        = r_err[TAG];

endmodule
`default_nettype wire
